// File: rtl/fetch_queue.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_queue : in-order instruction fetch with a {pc, instr} FIFO   |
// | and redirect flushing. FETCH_BYPASS_EN: empty-FIFO response bypass |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req_valid,
  output logic [63:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  input  logic        stall,
  output logic        valid_out,
  output logic [31:0] instruction_out,
  output logic [63:0] PC_out,
  output logic [63:0] PC_branch_link_out
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

  typedef enum logic [0:0] {FETCH = 1'b0, FLUSH = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [63:0]        fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   outstanding_q, outstanding_d;
  logic [CNT_W-1:0]   drop_q, drop_d;
  logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
  logic [PTR_W-1:0]   trk_head_q, trk_head_d, trk_tail_q, trk_tail_d;
  logic [31:0]        last_instr_q, last_instr_d;
  logic [63:0]        last_pc_q, last_pc_d;
  logic [63:0]        last_link_q, last_link_d;

  logic [63:0]        fifo_pc_q    [DEPTH];
  logic [31:0]        fifo_instr_q [DEPTH];
  logic [63:0]        trk_pc_q     [DEPTH];

  logic               w_fire, w_resp_ok, w_empty, w_bypass;
  logic               w_pop, w_fifo_pop, w_push;
  logic [63:0]        w_resp_pc;
  logic [CNT_W-1:0]   w_pending, w_drop_redir;

  assign w_empty   = (count_q == '0);
  assign w_resp_ok = imem_resp_valid && (state_q == FETCH) && (outstanding_q != '0);
  assign w_resp_pc = trk_pc_q[trk_head_q];

`ifdef FETCH_BYPASS_EN
  assign w_bypass = w_empty && w_resp_ok && !redirect;
`else
  assign w_bypass = 1'b0;
`endif

  assign imem_req_valid = !reset && (state_q == FETCH) && !redirect &&
                          (({1'b0, count_q} + {1'b0, outstanding_q}) < DEPTH_C);
  assign imem_req_addr  = fetch_pc_q;
  assign w_fire         = imem_req_valid && imem_req_ready;

  // When the FIFO is empty the outputs replay the last consumed entry.
  always_comb begin
    valid_out          = 1'b0;
    instruction_out    = last_instr_q;
    PC_out             = last_pc_q;
    PC_branch_link_out = last_link_q;
    if (w_bypass) begin
      valid_out          = 1'b1;
      instruction_out    = imem_resp_data;
      PC_out             = w_resp_pc;
      PC_branch_link_out = w_resp_pc + 64'd4;
    end else if (!w_empty) begin
      valid_out          = 1'b1;
      instruction_out    = fifo_instr_q[head_q];
      PC_out             = fifo_pc_q[head_q];
      PC_branch_link_out = fifo_pc_q[head_q] + 64'd4;
    end
  end

  assign w_pop      = valid_out && !stall && !redirect;
  assign w_fifo_pop = w_pop && !w_empty;
  assign w_push     = w_resp_ok && !redirect && !(w_bypass && !stall);

  assign w_pending    = outstanding_q + drop_q;
  assign w_drop_redir = w_pending - CNT_W'(imem_resp_valid && (w_pending != '0));

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    count_d       = count_q + CNT_W'(w_push) - CNT_W'(w_fifo_pop);
    outstanding_d = outstanding_q + CNT_W'(w_fire) - CNT_W'(w_resp_ok);
    drop_d        = drop_q;
    head_d        = w_fifo_pop ? head_q + 1'b1 : head_q;
    tail_d        = w_push ? tail_q + 1'b1 : tail_q;
    trk_head_d    = w_resp_ok ? trk_head_q + 1'b1 : trk_head_q;
    trk_tail_d    = w_fire ? trk_tail_q + 1'b1 : trk_tail_q;
    last_instr_d  = last_instr_q;
    last_pc_d     = last_pc_q;
    last_link_d   = last_link_q;

    if (w_fire) fetch_pc_d = fetch_pc_q + 64'd4;

    if (w_pop) begin
      last_instr_d = instruction_out;
      last_pc_d    = PC_out;
      last_link_d  = PC_branch_link_out;
    end

    if (state_q == FLUSH) begin
      if (imem_resp_valid && (drop_q != '0)) drop_d = drop_q - 1'b1;
      if (drop_d == '0) state_d = FETCH;
    end

    // Redirect overrides everything: stale requests become drop credits.
    if (redirect) begin
      fetch_pc_d    = redirect_pc;
      count_d       = '0;
      outstanding_d = '0;
      head_d        = '0;
      tail_d        = '0;
      trk_head_d    = '0;
      trk_tail_d    = '0;
      drop_d        = w_drop_redir;
      state_d       = (w_drop_redir != '0) ? FLUSH : FETCH;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= FETCH;
      fetch_pc_q    <= RESET_PC;
      count_q       <= '0;
      outstanding_q <= '0;
      drop_q        <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      trk_head_q    <= '0;
      trk_tail_q    <= '0;
      last_instr_q  <= '0;
      last_pc_q     <= '0;
      last_link_q   <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      trk_head_q    <= trk_head_d;
      trk_tail_q    <= trk_tail_d;
      last_instr_q  <= last_instr_d;
      last_pc_q     <= last_pc_d;
      last_link_q   <= last_link_d;
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) begin
      fifo_pc_q[tail_q]    <= w_resp_pc;
      fifo_instr_q[tail_q] <= imem_resp_data;
    end
    if (w_fire) trk_pc_q[trk_tail_q] <= fetch_pc_q;
  end
endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// tb_fetch_queue: per-cycle vector table plus a fire/pop scoreboard over a
// 1-cycle in-order memory model; hand sequences for redirect and wrap cases.
module tb_fetch_queue;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req_valid;
  logic [63:0] imem_req_addr;
  logic        imem_req_ready = 1'b1;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = 32'h0;
  logic        redirect = 1'b0;
  logic [63:0] redirect_pc = 64'h0;
  logic        stall = 1'b0;
  logic        valid_out;
  logic [31:0] instruction_out;
  logic [63:0] PC_out;
  logic [63:0] PC_branch_link_out;

  always #5 clock = ~clock;

  fetch_queue #(.DEPTH(4), .RESET_PC(64'h0)) dut (
    .clock(clock), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect(redirect), .redirect_pc(redirect_pc), .stall(stall),
    .valid_out(valid_out), .instruction_out(instruction_out),
    .PC_out(PC_out), .PC_branch_link_out(PC_branch_link_out)
  );

`ifdef FETCH_BYPASS_EN
  localparam int VLAT = 1;
`else
  localparam int VLAT = 2;
`endif

  typedef struct { logic [63:0] pc; logic [31:0] ins; } exp_t;
  typedef struct {
    bit do_rst; bit stall; bit req_valid; logic [63:0] req_addr; bit vout; logic [63:0] pc;
  } vec_t;

  int          errors = 0;
  int          checks = 0;
  logic [63:0] mem_q[$];
  exp_t        exp_q[$];
  bit          resp_en = 1'b1;
  bit          req_seen;
  logic [63:0] req_seen_addr;
  vec_t        vt[16];

  function automatic logic [31:0] mem_data(input logic [63:0] a);
    if (a == 64'h0) return 32'hD503201F;
    return a[31:0] ^ a[63:32] ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Observe the current cycle: memory accepts fires, scoreboard checks pops.
  task automatic sample();
    exp_t e;
    @(negedge clock);
    if (reset) begin
      mem_q.delete();
      exp_q.delete();
    end else begin
      if (imem_req_valid && imem_req_ready) begin
        mem_q.push_back(imem_req_addr);
        e.pc  = imem_req_addr;
        e.ins = mem_data(imem_req_addr);
        exp_q.push_back(e);
        if (!req_seen) begin
          req_seen      = 1'b1;
          req_seen_addr = imem_req_addr;
        end
      end
      if (valid_out && !stall && !redirect) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected_pop: got pc %h expected no output", PC_out);
        end else begin
          e = exp_q.pop_front();
          chk("sb_pc", PC_out, e.pc);
          chk("sb_instr", 64'(instruction_out), 64'(e.ins));
          chk("sb_link", PC_branch_link_out, e.pc + 64'd4);
        end
      end
      if (redirect) exp_q.delete();
    end
  endtask

  task automatic advance();
    logic [63:0] a;
    @(posedge clock);
    #1;
    if (!reset && resp_en && mem_q.size() > 0) begin
      a               = mem_q.pop_front();
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_data(a);
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'h0;
    end
  endtask

  task automatic tick();
    sample();
    advance();
  endtask

  task automatic do_reset();
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; imem_req_ready = 1'b1; resp_en = 1'b1;
    tick();
    tick();
    sample();
    chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
    chk("rst_valid_out", 64'(valid_out), 64'd0);
    chk("rst_instr", 64'(instruction_out), 64'd0);
    chk("rst_pc", PC_out, 64'd0);
    chk("rst_link", PC_branch_link_out, 64'd0);
    advance();
    reset = 1'b0;
  endtask

  // Leaves the bench at the sample point of the cycle where valid_out is seen.
  task automatic wait_valid(input string name);
    for (int k = 0; k < 30; k++) begin
      sample();
      if (valid_out) return;
      advance();
    end
    checks++;
    errors++;
    $display("FAIL %s: got no valid_out expected valid_out within 30 cycles", name);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 6; i++)
      vt[i] = '{i == 0, 1'b0, 1'b1, 64'(4 * i), i >= VLAT, (i >= VLAT) ? 64'(4 * (i - VLAT)) : 64'd0};
    for (int j = 0; j < 10; j++)
      vt[6 + j] = '{j == 0, 1'b1, j < 4, 64'(4 * j), j >= VLAT, 64'd0};

    for (int i = 0; i < 16; i++) begin
      if (vt[i].do_rst) do_reset();
      stall = vt[i].stall;
      sample();
      chk($sformatf("vec%0d_req_valid", i), 64'(imem_req_valid), 64'(vt[i].req_valid));
      if (vt[i].req_valid) chk($sformatf("vec%0d_req_addr", i), imem_req_addr, vt[i].req_addr);
      chk($sformatf("vec%0d_valid_out", i), 64'(valid_out), 64'(vt[i].vout));
      if (vt[i].vout) chk($sformatf("vec%0d_pc_out", i), PC_out, vt[i].pc);
      if (i == VLAT) chk("first_instr", 64'(instruction_out), 64'hD503201F);
      advance();
    end
    stall = 1'b0;
    for (int k = 0; k < 8; k++) tick();

    // Redirect with three requests outstanding and memory silent.
    do_reset();
    stall = 1'b1; resp_en = 1'b0;
    tick(); tick(); tick();
    imem_req_ready = 1'b0;
    tick();
    redirect = 1'b1; redirect_pc = 64'h400;
    sample();
    chk("redir_req_valid", 64'(imem_req_valid), 64'd0);
    advance();
    redirect = 1'b0; stall = 1'b0; req_seen = 1'b0;
    sample();
    chk("flush_req_valid", 64'(imem_req_valid), 64'd0);
    chk("flush_valid_out", 64'(valid_out), 64'd0);
    resp_en = 1'b1; imem_req_ready = 1'b1;
    advance();
    wait_valid("redir_wait");
    chk("redir_pc_out", PC_out, 64'h400);
    chk("redir_first_req", req_seen_addr, 64'h400);
    advance();

    // Redirect coinciding with a response and a stall.
    do_reset();
    stall = 1'b1;
    tick(); tick(); tick();
    redirect = 1'b1; redirect_pc = 64'h800;
    tick();
    redirect = 1'b0;
    sample();
    chk("coinc_valid_out", 64'(valid_out), 64'd0);
    chk("coinc_req_valid", 64'(imem_req_valid), 64'd1);
    chk("coinc_req_addr", imem_req_addr, 64'h800);
    advance();

    // 64-bit fetch address wrap.
    stall = 1'b0; redirect = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    redirect = 1'b0; req_seen = 1'b0;
    wait_valid("wrap_wait0");
    chk("wrap_pc0", PC_out, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_link0", PC_branch_link_out, 64'h0);
    chk("wrap_first_req", req_seen_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    advance();
    wait_valid("wrap_wait1");
    chk("wrap_pc1", PC_out, 64'h0);
    chk("wrap_link1", PC_branch_link_out, 64'h4);
    advance();
    for (int k = 0; k < 4; k++) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
